// File: rtl/spio_hss_multiplexer_frame_sched_if.sv
// Handshake bundle between the frame scheduler and its surroundings.
//   master : the scheduler side (drives ch_rq, frm_*, tout_*)
//   slave  : packet stores / transmitter / ack receiver side
// Signals:
//   ch_empty/ch_gt/ch_pres : per-channel store status and grant
//   ch_rq                  : broadcast read request to stores
//   frm_seq/frm_mask/frm_vld/frm_rdy : frame hand-off to the transmitter
//   ack/nak/ack_seq        : remote acknowledge strobes
//   tout_nak/tout_seq      : local timeout nak strobe and its sequence
interface spio_hss_multiplexer_frame_sched_if #(
    parameter int NUM_CH   = 8,
    parameter int SEQ_BITS = 7
);
    logic [NUM_CH-1:0]   ch_empty;
    logic [NUM_CH-1:0]   ch_rq;
    logic [NUM_CH-1:0]   ch_gt;
    logic [NUM_CH-1:0]   ch_pres;
    logic [SEQ_BITS-1:0] frm_seq;
    logic [NUM_CH-1:0]   frm_mask;
    logic                frm_vld;
    logic                frm_rdy;
    logic                ack;
    logic                nak;
    logic [SEQ_BITS-1:0] ack_seq;
    logic                tout_nak;
    logic [SEQ_BITS-1:0] tout_seq;

    modport master (
        input  ch_empty, ch_gt, ch_pres, frm_rdy, ack, nak, ack_seq,
        output ch_rq, frm_seq, frm_mask, frm_vld, tout_nak, tout_seq
    );

    modport slave (
        output ch_empty, ch_gt, ch_pres, frm_rdy, ack, nak, ack_seq,
        input  ch_rq, frm_seq, frm_mask, frm_vld, tout_nak, tout_seq
    );
endinterface

// File: rtl/spio_hss_multiplexer_frame_sched.sv
// Frame scheduler for the HSS multiplexer: polls the packet stores, builds a
// frame out of whichever channels grant a packet, hands it to the transmitter
// and keeps a sliding window of unacknowledged frames with go-back-N rewind on
// remote nak or local resend timeout.
// Ports:
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : scheduler side (master) of spio_hss_multiplexer_frame_sched_if
module spio_hss_multiplexer_frame_sched #(
    parameter int NUM_CH    = 8,
    parameter int SEQ_BITS  = 7,
    parameter int WIN       = 15,
    parameter int TOUT_BITS = 10,
    parameter int TOUT_VAL  = 1000
) (
    input  logic clk,
    input  logic rst,
    spio_hss_multiplexer_frame_sched_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ISSUE = 2'd3;

    localparam logic [SEQ_BITS-1:0]  WIN_L     = SEQ_BITS'(WIN);
    localparam logic [TOUT_BITS-1:0] TOUT_LAST = TOUT_BITS'(TOUT_VAL - 1);

    logic [1:0]           state;
    logic [SEQ_BITS-1:0]  seq;          // sequence of the next frame to issue
    logic [SEQ_BITS-1:0]  base;         // oldest unacknowledged frame
    logic [SEQ_BITS-1:0]  nak_seq_l;
    logic                 nak_pend;
    logic [TOUT_BITS-1:0] timer;
    logic [NUM_CH-1:0]    mask;

    logic [SEQ_BITS-1:0]  outstanding;
    logic [NUM_CH-1:0]    grant_mask;
    logic                 any_data;
    logic                 win_open;
    logic                 issue_hs;
    logic                 tout_fire;

    // Modular distance works across the sequence wrap.
    assign outstanding = seq - base;
    assign win_open    = outstanding < WIN_L;
    assign any_data    = ~&bus.ch_empty;
    assign grant_mask  = bus.ch_gt & bus.ch_pres;
    assign issue_hs    = (state == ISSUE) && bus.frm_rdy;

    // A remote ack/nak in the same cycle supersedes the local timeout.
    assign tout_fire = (timer == TOUT_LAST) && (outstanding != '0) &&
                       !bus.ack && !bus.nak;

    assign bus.ch_rq    = (state == REQ) ? '1 : '0;
    assign bus.frm_vld  = (state == ISSUE);
    assign bus.frm_seq  = seq;
    assign bus.frm_mask = mask;
    assign bus.tout_nak = tout_fire;
    assign bus.tout_seq = base;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            seq       <= '0;
            base      <= '0;
            nak_seq_l <= '0;
            nak_pend  <= 1'b0;
            timer     <= '0;
            mask      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A pending rewind costs one IDLE cycle before new polling.
                    if (nak_pend) begin
                        seq      <= nak_seq_l;
                        base     <= nak_seq_l;
                        nak_pend <= 1'b0;
                    end else if (any_data && win_open) begin
                        state <= REQ;
                    end
                end
                REQ:  state <= WAIT;
                WAIT: begin
                    mask  <= grant_mask;
                    state <= (|grant_mask) ? ISSUE : IDLE;
                end
                ISSUE: begin
                    if (bus.frm_rdy) begin
                        seq   <= seq + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed after the FSM so a fresh nak re-arms nak_pend even in the
            // cycle an older one is being applied.
            if (bus.nak) begin
                nak_pend  <= 1'b1;
                nak_seq_l <= bus.ack_seq;
            end else if (bus.ack) begin
                base <= bus.ack_seq;
            end else if (tout_fire) begin
                nak_pend  <= 1'b1;
                nak_seq_l <= base;
            end

            if (bus.ack || bus.nak || issue_hs || tout_fire || (outstanding == '0))
                timer <= '0;
            else if (timer != '1)
                timer <= timer + 1'b1;
        end
    end
endmodule

// File: tb/tb_spio_hss_multiplexer_frame_sched.sv
// Self-checking bench for spio_hss_multiplexer_frame_sched: directed scenarios
// followed by a randomized run checked against a frame-level window model.
module tb_spio_hss_multiplexer_frame_sched;
    localparam int NUM_CH = 8, SEQ_BITS = 7, WIN = 15, TOUT_BITS = 10, TOUT_VAL = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spio_hss_multiplexer_frame_sched_if #(.NUM_CH(NUM_CH), .SEQ_BITS(SEQ_BITS)) bus ();

    spio_hss_multiplexer_frame_sched #(
        .NUM_CH(NUM_CH), .SEQ_BITS(SEQ_BITS), .WIN(WIN),
        .TOUT_BITS(TOUT_BITS), .TOUT_VAL(TOUT_VAL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n;
    logic [6:0] s7, a7;
    logic [7:0] m8;

    // random-phase model state
    logic [6:0] m_seq, m_base, m_out, snap_cur, snap_prev, exp_mask7;
    logic [7:0] exp_mask, prev_empty;
    logic       in_frame, rewound;
    int         wait_at, k;
    int         q_cyc[$];
    logic [6:0] q_val[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven just after the rising edge, outputs sampled on the falling edge.
    task automatic nxt();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_req(input logic [6:0] s, input string tag);
        int w;
        nxt(); bus.ch_empty = 8'h00; smp();
        w = 0;
        while (bus.ch_rq !== 8'hFF && w < 40) begin
            nxt(); smp(); w++;
        end
        chk({tag, "_rq"}, bus.ch_rq, 8'hFF);
        chk({tag, "_req_seq"}, bus.frm_seq, s);
    endtask

    task automatic finish_frame(input logic [7:0] m, input logic [6:0] s, input string tag);
        logic [6:0] nx;
        nx = s + 7'd1;
        nxt(); bus.ch_empty = 8'hFF; bus.ch_gt = m; bus.ch_pres = m; bus.frm_rdy = 1'b0; smp();
        chk({tag, "_wait_vld"}, bus.frm_vld, 1'b0);
        nxt(); bus.ch_gt = 8'h00; bus.ch_pres = 8'h00; bus.frm_rdy = 1'b1; smp();
        chk({tag, "_vld"}, bus.frm_vld, 1'b1);
        chk({tag, "_seq"}, bus.frm_seq, s);
        chk({tag, "_mask"}, bus.frm_mask, m);
        nxt(); bus.frm_rdy = 1'b0; smp();
        chk({tag, "_after_vld"}, bus.frm_vld, 1'b0);
        chk({tag, "_next_seq"}, bus.frm_seq, nx);
    endtask

    task automatic send_ack(input logic [6:0] v);
        nxt(); bus.ack = 1'b1; bus.ack_seq = v; smp();
        nxt(); bus.ack = 1'b0; smp();
    endtask

    initial begin
        rst = 1'b1;
        bus.ch_empty = 8'hFF; bus.ch_gt = 8'h00; bus.ch_pres = 8'h00;
        bus.frm_rdy = 1'b0; bus.ack = 1'b0; bus.nak = 1'b0; bus.ack_seq = 7'd0;

        // ---- reset state
        nxt(); nxt(); smp();
        chk("rst_vld", bus.frm_vld, 1'b0);
        chk("rst_rq", bus.ch_rq, 8'h00);
        chk("rst_seq", bus.frm_seq, 7'd0);
        chk("rst_mask", bus.frm_mask, 8'h00);
        chk("rst_tout", bus.tout_nak, 1'b0);
        chk("rst_tout_seq", bus.tout_seq, 7'd0);

        // ---- basic latency: IDLE, REQ, WAIT, ISSUE
        nxt(); rst = 1'b0; bus.ch_empty = 8'hFE; bus.frm_rdy = 1'b1; smp();
        chk("lat_idle_rq", bus.ch_rq, 8'h00);
        nxt(); smp();
        chk("lat_req_rq", bus.ch_rq, 8'hFF);
        chk("lat_req_seq", bus.frm_seq, 7'd0);
        nxt(); bus.ch_gt = 8'h01; bus.ch_pres = 8'h01; smp();
        chk("lat_wait_rq", bus.ch_rq, 8'h00);
        chk("lat_wait_vld", bus.frm_vld, 1'b0);
        nxt(); bus.ch_gt = 8'h00; bus.ch_pres = 8'h00; bus.ch_empty = 8'hFF; smp();
        chk("lat_issue_vld", bus.frm_vld, 1'b1);
        chk("lat_issue_seq", bus.frm_seq, 7'd0);
        chk("lat_issue_mask", bus.frm_mask, 8'h01);
        nxt(); bus.frm_rdy = 1'b0; smp();
        chk("lat_done_vld", bus.frm_vld, 1'b0);
        chk("lat_done_seq", bus.frm_seq, 7'd1);
        send_ack(7'd1);

        // ---- window full after 15 unacked frames
        for (int si = 1; si <= 15; si++) begin
            s7 = 7'(si); m8 = 8'(si) | 8'h01;
            wait_req(s7, "win"); finish_frame(m8, s7, "win");
        end
        nxt(); bus.ch_empty = 8'h00; smp();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.ch_rq !== 8'h00) n++;
            nxt(); smp();
        end
        chk("win_full_no_rq", n, 0);
        nxt(); bus.ack = 1'b1; bus.ack_seq = 7'd6; smp();
        chk("win_ack_rq0", bus.ch_rq, 8'h00);
        nxt(); bus.ack = 1'b0; smp();
        chk("win_ack_rq1", bus.ch_rq, 8'h00);
        nxt(); smp();
        chk("win_resume_rq", bus.ch_rq, 8'hFF);
        chk("win_resume_seq", bus.frm_seq, 7'd16);
        finish_frame(8'h81, 7'd16, "win_resume");
        send_ack(7'd17);

        // ---- sequence wrap with base = 120
        for (int si = 17; si <= 127; si++) begin
            s7 = 7'(si); m8 = 8'(si) | 8'h01;
            wait_req(s7, "wrap"); finish_frame(m8, s7, "wrap");
            if (si < 120) begin
                a7 = 7'(si + 1);
                send_ack(a7);
            end
        end
        chk("wrap_seq0", bus.frm_seq, 7'd0);
        chk("wrap_base", bus.tout_seq, 7'd120);
        // outstanding is 8 here, so exactly 7 more frames fit
        for (int si = 0; si <= 6; si++) begin
            s7 = 7'(si);
            wait_req(s7, "wrap2"); finish_frame(8'h10, s7, "wrap2");
        end
        nxt(); bus.ch_empty = 8'h00; smp();
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.ch_rq !== 8'h00) n++;
            nxt(); smp();
        end
        chk("wrap_win_full", n, 0);

        // ---- nak during a held ISSUE
        nxt(); bus.ch_empty = 8'hFF; smp();
        send_ack(7'd3);
        wait_req(7'd7, "nakh");
        nxt(); bus.ch_empty = 8'hFF; bus.ch_gt = 8'h0C; bus.ch_pres = 8'h0E; bus.frm_rdy = 1'b0; smp();
        nxt(); bus.ch_gt = 8'h00; bus.ch_pres = 8'h00; bus.nak = 1'b1; bus.ack_seq = 7'd3; smp();
        chk("nakh_vld0", bus.frm_vld, 1'b1);
        chk("nakh_seq0", bus.frm_seq, 7'd7);
        for (int i = 0; i < 3; i++) begin
            nxt(); bus.nak = 1'b0; smp();
            chk("nakh_hold_vld", bus.frm_vld, 1'b1);
            chk("nakh_hold_seq", bus.frm_seq, 7'd7);
            chk("nakh_hold_mask", bus.frm_mask, 8'h0C);
        end
        nxt(); bus.frm_rdy = 1'b1; smp();
        chk("nakh_accept_vld", bus.frm_vld, 1'b1);
        nxt(); bus.frm_rdy = 1'b0; smp();
        chk("nakh_idle_seq", bus.frm_seq, 7'd8);
        nxt(); smp();
        chk("nakh_rewind_seq", bus.frm_seq, 7'd3);
        chk("nakh_rewind_base", bus.tout_seq, 7'd3);
        chk("nakh_rewind_rq", bus.ch_rq, 8'h00);

        // ---- ack and nak in the same cycle: only the nak acts
        for (int si = 3; si <= 5; si++) begin
            s7 = 7'(si);
            wait_req(s7, "an"); finish_frame(8'h20, s7, "an");
        end
        nxt(); bus.ack = 1'b1; bus.nak = 1'b1; bus.ack_seq = 7'd4; smp();
        nxt(); bus.ack = 1'b0; bus.nak = 1'b0; smp();
        nxt(); smp();
        chk("an_seq", bus.frm_seq, 7'd4);
        chk("an_base", bus.tout_seq, 7'd4);

        // ---- resend timeout with two frames outstanding
        wait_req(7'd4, "to"); finish_frame(8'h40, 7'd4, "to");
        wait_req(7'd5, "to"); finish_frame(8'h40, 7'd5, "to");
        n = 0;
        while (bus.tout_nak !== 1'b1 && n < 1100) begin
            nxt(); smp(); n++;
        end
        chk("to_latency", n, TOUT_VAL - 1);
        chk("to_pulse", bus.tout_nak, 1'b1);
        chk("to_seq", bus.tout_seq, 7'd4);
        nxt(); smp();
        chk("to_single", bus.tout_nak, 1'b0);
        nxt(); smp();
        chk("to_rewind_seq", bus.frm_seq, 7'd4);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            nxt(); smp();
            if (bus.tout_nak !== 1'b0) n++;
        end
        chk("to_quiet", n, 0);

        // ---- reset in the middle of an ISSUE handshake
        wait_req(7'd4, "rsti");
        nxt(); bus.ch_empty = 8'hFF; bus.ch_gt = 8'h03; bus.ch_pres = 8'h03; bus.frm_rdy = 1'b0; smp();
        nxt(); bus.ch_gt = 8'h00; bus.ch_pres = 8'h00; smp();
        chk("rsti_vld_before", bus.frm_vld, 1'b1);
        nxt(); rst = 1'b1; smp();
        nxt(); rst = 1'b0; smp();
        chk("rsti_vld", bus.frm_vld, 1'b0);
        chk("rsti_seq", bus.frm_seq, 7'd0);
        chk("rsti_mask", bus.frm_mask, 8'h00);
        chk("rsti_rq", bus.ch_rq, 8'h00);
        chk("rsti_base", bus.tout_seq, 7'd0);

        // ---- randomized run against a frame-level window model
        m_seq = 7'd0; m_base = 7'd0; snap_prev = 7'd0; prev_empty = 8'hFF;
        in_frame = 1'b0; wait_at = -10; exp_mask = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            nxt();
            bus.ch_empty = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
            bus.ch_gt    = 8'($urandom);
            bus.ch_pres  = 8'($urandom);
            bus.frm_rdy  = 1'($urandom_range(1));
            bus.ack = 1'b0; bus.nak = 1'b0;
            m_out = m_seq - m_base;
            if ($urandom_range(49) == 0) begin
                bus.nak = 1'b1;
                bus.ack = 1'($urandom_range(1));
                bus.ack_seq = m_base + 7'($urandom_range({25'd0, m_out}));
            end else if (q_cyc.size() == 0 && $urandom_range(5) == 0) begin
                bus.ack = 1'b1;
                bus.ack_seq = m_base + 7'($urandom_range({25'd0, m_out}));
            end
            smp();
            snap_cur = m_seq - m_base;

            chk("rnd_tout", bus.tout_nak, 1'b0);
            if (q_cyc.size() == 0) chk("rnd_tout_seq", bus.tout_seq, m_base);

            chk("rnd_vld", bus.frm_vld, in_frame);
            if (in_frame && bus.frm_vld === 1'b1) begin
                chk("rnd_frm_seq", bus.frm_seq, m_seq);
                chk("rnd_frm_mask", bus.frm_mask, exp_mask);
                if (bus.frm_rdy) begin
                    m_seq = m_seq + 7'd1;
                    in_frame = 1'b0;
                end
            end

            if (bus.ch_rq !== 8'h00) begin
                chk("rnd_rq_ones", bus.ch_rq, 8'hFF);
                chk("rnd_rq_data", prev_empty != 8'hFF, 1'b1);
                // every nak at least two cycles old has been applied by now
                k = -1;
                for (int j = 0; j < q_cyc.size(); j++)
                    if (q_cyc[j] <= cyc - 2) k = j;
                rewound = (k >= 0);
                if (rewound) begin
                    m_seq = q_val[k]; m_base = q_val[k];
                    for (int j = 0; j <= k; j++) begin
                        void'(q_cyc.pop_front());
                        void'(q_val.pop_front());
                    end
                end else begin
                    chk("rnd_win", snap_prev < WIN, 1'b1);
                end
                chk("rnd_req_seq", bus.frm_seq, m_seq);
                wait_at = cyc + 1;
            end

            if (cyc == wait_at) begin
                exp_mask = bus.ch_gt & bus.ch_pres;
                in_frame = (exp_mask != 8'h00);
            end

            if (bus.nak) begin
                q_cyc.push_back(cyc);
                exp_mask7 = bus.ack_seq;
                q_val.push_back(exp_mask7);
            end else if (bus.ack) begin
                m_base = bus.ack_seq;
            end

            snap_prev  = snap_cur;
            prev_empty = bus.ch_empty;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spio_hss_multiplexer_frame_sched.md
SPIO_HSS_MULTIPLEXER_FRAME_SCHED -- requirements
Module: spio_hss_multiplexer_frame_sched

Interface
REQ-001 SHALL have parameters: NUM_CH, 8, number of packet-store channels; SEQ_BITS, 7, frame sequence width; WIN, 15, maximum unacknowledged frames (1..2^SEQ_BITS-1); TOUT_BITS, 10, timeout counter width; TOUT_VAL, 1000, resend timeout in clk cycles.
REQ-002 SHALL have clk  in  1  single clock, all logic rising-edge.
REQ-003 SHALL have rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ch_empty  in  NUM_CH  per-channel store empty flags.
REQ-005 SHALL have ch_rq  out  NUM_CH  broadcast read request to stores.
REQ-006 SHALL have ch_gt  in  NUM_CH  per-channel grant from stores.
REQ-007 SHALL have ch_pres  in  NUM_CH  per-channel packet present, valid with ch_gt.
REQ-008 SHALL have frm_seq  out  SEQ_BITS  sequence number of the frame being built/issued.
REQ-009 SHALL have frm_mask  out  NUM_CH  channels contributing a packet to the frame.
REQ-010 SHALL have frm_vld  out  1  frame ready for transmit; frm_rdy  in  1  transmitter accept.
REQ-011 SHALL have ack, nak  in  1 each  remote ack/nak strobes; ack_seq  in  SEQ_BITS  their sequence.
REQ-012 SHALL have tout_nak  out  1  one-cycle local nak strobe; tout_seq  out  SEQ_BITS  its sequence.

Function
REQ-013 SHALL keep registers seq (next frame sequence), base (oldest unacked), nak_pend, nak_seq_l, timer.
REQ-014 SHALL compute outstanding = (seq - base) mod 2^SEQ_BITS, SEQ_BITS wide.
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT, ISSUE.
REQ-016 IDLE: if nak_pend, set seq and base to nak_seq_l, clear nak_pend, stay IDLE one cycle; else if any !ch_empty and outstanding < WIN, go REQ; else stay.
REQ-017 REQ: assert ch_rq = all ones for exactly one cycle with frm_seq = seq; go WAIT.
REQ-018 WAIT: capture frm_mask = ch_gt & ch_pres; if nonzero go ISSUE, else go IDLE with seq unchanged.
REQ-019 ISSUE: frm_vld = 1, frm_seq and frm_mask stable until frm_rdy; on frm_vld & frm_rdy, seq <= seq + 1 (wraps to 0), go IDLE.
REQ-020 Latency rdy-to-rdy: empty-to-frm_vld SHALL be 3 cycles from IDLE with data available (IDLE, REQ, WAIT, then ISSUE).
REQ-021 ack (no nak same cycle): base <= ack_seq (frame ack_seq not acknowledged, all prior are).
REQ-022 nak: nak_pend <= 1, nak_seq_l <= ack_seq; any in-progress REQ/WAIT/ISSUE SHALL complete normally, rewind applied at next IDLE.
REQ-023 nak and ack in the same cycle: nak wins, ack ignored.
REQ-024 Second nak while nak_pend: nak_seq_l overwritten by newest value.
REQ-025 timer: cleared on ack, nak, frame issue, or outstanding == 0; otherwise increments, saturating.
REQ-026 timer == TOUT_VAL - 1 with outstanding != 0 and no ack/nak that cycle: pulse tout_nak one cycle, tout_seq = base, set nak_pend with nak_seq_l = base, clear timer.
REQ-027 tout_seq SHALL equal base at all times; tout_nak SHALL never be asserted for two consecutive cycles.
REQ-028 ch_rq SHALL be zero outside REQ; frm_vld SHALL be zero outside ISSUE.

Reset
REQ-029 rst SHALL force IDLE, seq = 0, base = 0, nak_pend = 0, timer = 0, frm_mask = 0, frm_vld = 0, ch_rq = 0, tout_nak = 0 at next edge, in any state including ISSUE mid-handshake.

Verification
REQ-030 ch_empty = 8'hFE, ch_gt/ch_pres = 8'h01 in WAIT, frm_rdy = 1 -> frm_vld on cycle 3 with frm_seq = 0, frm_mask = 8'h01; seq becomes 1.
REQ-031 No acks, 15 frames issued (WIN = 15) -> outstanding = 15, no further ch_rq; ack with ack_seq = 5 -> REQ resumes next IDLE cycle.
REQ-032 seq = 127, frame accepted -> frm_seq wraps to 0; outstanding computed correctly with base = 120 (8).
REQ-033 nak with ack_seq = 3 during ISSUE, frm_rdy low 4 cycles -> frame 7 held then issued, then IDLE sets seq = base = 3.
REQ-034 Outstanding = 2, no ack for TOUT_VAL cycles -> single tout_nak pulse, tout_seq = base, seq rewound to base.
REQ-035 rst asserted while frm_vld = 1 -> frm_vld = 0, seq = 0 next cycle; ack and nak same cycle -> nak behaviour only.
